// File: rtl/ohsm_pkg.sv
// Shared widths, FSM state encoding and helpers for the ohsm sequencer.
// Pure declarations: no latency, no flow control.
package ohsm_pkg;

   localparam int S_W   = 4;
   localparam int CNT_W = 8;
   localparam int TO_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DWELL,
      ST_PULSE,
      ST_WAIT_ACK,
      ST_ERR
   } seq_state_t;

   function automatic logic is_onehot(input logic [S_W-1:0] s);
      return $countones(s) == 1;
   endfunction

endpackage

// File: rtl/ohsm_dwell_ctr.sv
// Loadable down-counter with a zero flag; used for both dwell and ack timeout.
// Load/decrement take effect at the next edge; the counter holds at zero.
module ohsm_dwell_ctr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/ohsm_sequencer.sv
// Issues start pulses to ohsm (dwell timer or manual request), confirms via SGlobal, counts steps.
// All outputs registered; start lasts one cycle; OHSM_SEQ_ONEHOT_CHECK_EN adds a one-hot ack check.
module ohsm_sequencer
   import ohsm_pkg::*;
#(
   parameter int DWELL_CYCLES = 8,
   parameter int TIMEOUT      = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             manual_req,
   input  logic             clr_err,
   input  logic [S_W-1:0]   SGlobal,
   output logic             start,
   output logic             busy,
   output logic             step_done,
   output logic             err,
   output logic [CNT_W-1:0] step_cnt
);

   localparam logic [CNT_W-1:0] DWELL_INIT = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_INIT    = TO_W'(TIMEOUT - 1);

   seq_state_t     state;
   seq_state_t     state_nxt;
   logic [S_W-1:0] prev_s;
   logic           pending;
   logic           pending_nxt;
   logic           dwell_load;
   logic           dwell_dec;
   logic           dwell_zero;
   logic           to_load;
   logic           to_dec;
   logic           to_zero;
   logic           bad;
   logic           ack;
   logic           ack_fire;

   ohsm_dwell_ctr #(.W(CNT_W)) u_dwell_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (dwell_load),
      .load_val (DWELL_INIT),
      .dec      (dwell_dec),
      .zero     (dwell_zero)
   );

   ohsm_dwell_ctr #(.W(TO_W)) u_timeout_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (to_load),
      .load_val (TO_INIT),
      .dec      (to_dec),
      .zero     (to_zero)
   );

`ifdef OHSM_SEQ_ONEHOT_CHECK_EN
   assign bad = !is_onehot(SGlobal);
`else
   assign bad = 1'b0;
`endif

   assign ack = (SGlobal != prev_s) && !bad;

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      dwell_load  = 1'b0;
      dwell_dec   = 1'b0;
      to_load     = 1'b0;
      to_dec      = 1'b0;
      ack_fire    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (manual_req) begin
               state_nxt = ST_PULSE;
            end else if (en) begin
               state_nxt  = ST_DWELL;
               dwell_load = 1'b1;
            end
         end
         ST_DWELL: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else if (manual_req || dwell_zero) begin
               state_nxt = ST_PULSE;
            end else begin
               dwell_dec = 1'b1;
            end
         end
         ST_PULSE: begin
            to_load     = 1'b1;
            state_nxt   = ST_WAIT_ACK;
            pending_nxt = pending | manual_req;
         end
         ST_WAIT_ACK: begin
            // A request arriving in the ack cycle itself is served like a pending one.
            pending_nxt = pending | manual_req;
            if (bad) begin
               state_nxt = ST_ERR;
            end else if (ack) begin
               ack_fire = 1'b1;
               if (pending || manual_req) begin
                  state_nxt   = ST_PULSE;
                  pending_nxt = 1'b0;
               end else if (en) begin
                  state_nxt  = ST_DWELL;
                  dwell_load = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (to_zero) begin
               state_nxt = ST_ERR;
            end else begin
               to_dec = 1'b1;
            end
         end
         ST_ERR: begin
            if (clr_err) begin
               state_nxt   = ST_IDLE;
               pending_nxt = 1'b0;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         pending   <= 1'b0;
         prev_s    <= '0;
         start     <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         step_done <= 1'b0;
         step_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         if (state == ST_PULSE) begin
            prev_s <= SGlobal;
         end
         start     <= (state_nxt == ST_PULSE);
         busy      <= (state_nxt == ST_PULSE) || (state_nxt == ST_WAIT_ACK);
         err       <= (state_nxt == ST_ERR);
         step_done <= ack_fire;
         if (ack_fire) begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ohsm_sequencer.sv
// Self-checking bench for ohsm_sequencer with a behavioural one-hot ring standing in for ohsm.
module tb_ohsm_sequencer;

   localparam int DW = 3;
   localparam int TO = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       manual_req;
   logic       clr_err;
   logic [3:0] SGlobal;
   logic [3:0] sg_model;
   logic [3:0] sg_force;
   logic       force_mode;
   logic       start;
   logic       busy;
   logic       step_done;
   logic       err;
   logic [7:0] step_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] sb_q[$];
   int         due_q[$];
   logic [7:0] exp_cnt;

   ohsm_sequencer #(.DWELL_CYCLES(DW), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .manual_req (manual_req),
      .clr_err    (clr_err),
      .SGlobal    (SGlobal),
      .start      (start),
      .busy       (busy),
      .step_done  (step_done),
      .err        (err),
      .step_cnt   (step_cnt)
   );

   always #5 clk = ~clk;

   // ohsm stand-in: rotate the one-hot state on each start pulse
   always @(posedge clk) begin
      if (reset) sg_model <= 4'b0001;
      else if (start) sg_model <= {sg_model[2:0], sg_model[3]};
   end

   assign SGlobal = force_mode ? sg_force : sg_model;

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; manual_req = 1'b0; clr_err = 1'b0;
      force_mode = 1'b0; sg_force = 4'b0000;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      sb_q.delete();
      due_q.delete();
      exp_cnt = 8'd0;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; manual_req = 1'b1; clr_err = 1'b0;
      force_mode = 1'b0; sg_force = 4'b0000;
      repeat (3) @(negedge clk);
      n_tests++;
      if ({start, busy, step_done, err, step_cnt} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_outputs: got start=%b busy=%b done=%b err=%b cnt=%0d, want all 0",
                  start, busy, step_done, err, step_cnt);
      end
      en = 1'b0; manual_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({start, busy, err} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got start=%b busy=%b err=%b, want 000", start, busy, err);
      end
   endtask

   task automatic test_auto();
      int         t_start[$];
      logic [7:0] e;
      int         d;
      bit         err_seen;
      do_reset();
      err_seen = 1'b0;
      en = 1'b1;
      for (int t = 1; t <= 22; t++) begin
         @(negedge clk);
         if (err) err_seen = 1'b1;
         if (start) begin
            t_start.push_back(t);
            exp_cnt = exp_cnt + 8'd1;
            sb_q.push_back(exp_cnt);
            due_q.push_back(t + 2);
         end
         if (step_done) begin
            n_tests++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL auto_done: unexpected step_done at t=%0d", t);
            end else begin
               e = sb_q.pop_front();
               d = due_q.pop_front();
               if (step_cnt !== e || t != d) begin
                  n_fail++;
                  $display("FAIL auto_done: got cnt=%0d at t=%0d, want cnt=%0d at t=%0d", step_cnt, t, e, d);
               end
            end
         end
      end
      en = 1'b0;
      n_tests++;
      if (t_start.size() != 4) begin
         n_fail++;
         $display("FAIL auto_pulses: got %0d start pulses, want 4", t_start.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (t_start[i] != 4 + 5 * i) begin
               n_fail++;
               $display("FAIL auto_start_time: pulse %0d at t=%0d, want t=%0d", i, t_start[i], 4 + 5 * i);
            end
         end
      end
      n_tests++;
      if (err_seen || step_cnt !== 8'd4 || sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL auto_final: got err_seen=%b cnt=%0d unconfirmed=%0d, want 0/4/0",
                  err_seen, step_cnt, sb_q.size());
      end
   endtask

   task automatic test_manual_pending();
      int         nst;
      int         first;
      int         second;
      logic [7:0] e;
      for (int v = 0; v < 2; v++) begin
         do_reset();
         nst = 0; first = -1; second = -1;
         manual_req = 1'b1;
         sb_q.push_back(8'd1);
         sb_q.push_back(8'd2);
         for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            manual_req = (t == 1 && v == 1) || (t == 2);
            if (start) begin
               nst++;
               if (first < 0) first = t;
               else second = t;
            end
            if (step_done) begin
               n_tests++;
               if (sb_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL manual_done: unexpected step_done v=%0d t=%0d", v, t);
               end else begin
                  e = sb_q.pop_front();
                  if (step_cnt !== e) begin
                     n_fail++;
                     $display("FAIL manual_done: v=%0d got cnt=%0d want %0d", v, step_cnt, e);
                  end
               end
            end
         end
         n_tests++;
         if (nst != 2 || first != 1 || second != 3) begin
            n_fail++;
            $display("FAIL manual_pulses: v=%0d got %0d pulses at t=%0d,%0d, want 2 at t=1,3",
                     v, nst, first, second);
         end
         n_tests++;
         if (step_cnt !== 8'd2 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL manual_cnt: v=%0d got cnt=%0d unconfirmed=%0d, want 2/0", v, step_cnt, sb_q.size());
         end
      end
   endtask

   task automatic test_timeout();
      int pulse_t;
      int rise_t;
      int nst;
      bit err_dropped;
      do_reset();
      manual_req = 1'b1;
      @(negedge clk);
      manual_req = 1'b0;
      repeat (5) @(negedge clk);
      force_mode = 1'b1; sg_force = 4'b0001;
      manual_req = 1'b1;
      pulse_t = -1; rise_t = -1;
      for (int t = 1; t <= 10; t++) begin
         @(negedge clk);
         manual_req = (t == 2);
         if (start && pulse_t < 0) pulse_t = t;
         if (err && rise_t < 0) rise_t = t;
      end
      n_tests++;
      if (pulse_t != 1 || rise_t != 6) begin
         n_fail++;
         $display("FAIL timeout_err: got pulse t=%0d err rise t=%0d, want 1 and 6", pulse_t, rise_t);
      end
      nst = 0; err_dropped = 1'b0;
      en = 1'b1; manual_req = 1'b1;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         manual_req = 1'b0;
         if (start || busy) nst++;
         if (!err) err_dropped = 1'b1;
      end
      en = 1'b0;
      n_tests++;
      if (nst != 0 || err_dropped) begin
         n_fail++;
         $display("FAIL err_sticky: got %0d busy cycles, err_dropped=%b, want 0/0", nst, err_dropped);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      n_tests++;
      if (err !== 1'b0 || busy !== 1'b0 || step_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL clr_err: got err=%b busy=%b cnt=%0d, want 0/0/1", err, busy, step_cnt);
      end
      force_mode = 1'b0;
      manual_req = 1'b1;
      nst = 0;
      for (int t = 1; t <= 8; t++) begin
         @(negedge clk);
         manual_req = 1'b0;
         if (start) nst++;
      end
      n_tests++;
      if (nst != 1 || step_cnt !== 8'd2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL after_clr: got %0d pulses cnt=%0d err=%b, want 1/2/0", nst, step_cnt, err);
      end
   endtask

   task automatic test_onehot();
      do_reset();
      manual_req = 1'b1;
      @(negedge clk);
      manual_req = 1'b0;
      n_tests++;
      if (start !== 1'b1) begin
         n_fail++;
         $display("FAIL onehot_pulse: got start=%b, want 1", start);
      end
      @(negedge clk);
      force_mode = 1'b1; sg_force = 4'b0011;
      @(negedge clk);
      n_tests++;
`ifdef OHSM_SEQ_ONEHOT_CHECK_EN
      if (err !== 1'b1 || step_done !== 1'b0 || step_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL onehot_check: got err=%b done=%b cnt=%0d, want 1/0/0", err, step_done, step_cnt);
      end
`else
      if (err !== 1'b0 || step_done !== 1'b1 || step_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL onehot_check: got err=%b done=%b cnt=%0d, want 0/1/1", err, step_done, step_cnt);
      end
`endif
      force_mode = 1'b0;
   endtask

   task automatic test_wrap_reset();
      int         ndone;
      bit         wrap_ok;
      bit         hit;
      logic [7:0] e;
      do_reset();
      ndone = 0; wrap_ok = 1'b0; hit = 1'b0;
      en = 1'b1;
      for (int t = 0; t < 2000 && ndone < 257; t++) begin
         @(negedge clk);
         if (start) begin
            exp_cnt = exp_cnt + 8'd1;
            sb_q.push_back(exp_cnt);
         end
         if (step_done) begin
            ndone++;
            n_tests++;
            e = (sb_q.size() != 0) ? sb_q.pop_front() : 8'hxx;
            if (step_cnt !== e) begin
               n_fail++;
               $display("FAIL wrap_cnt: step %0d got cnt=%0d want %0d", ndone, step_cnt, e);
            end
            if (ndone == 256 && step_cnt === 8'd0) wrap_ok = 1'b1;
         end
      end
      n_tests++;
      if (ndone != 257 || !wrap_ok) begin
         n_fail++;
         $display("FAIL wrap: got %0d steps wrap_to_0=%b, want 257 steps and wrap", ndone, wrap_ok);
      end
      for (int t = 0; t < 20 && !hit; t++) begin
         @(negedge clk);
         if (start) begin
            hit = 1'b1;
            reset = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({start, busy, step_cnt} !== 10'h000) begin
               n_fail++;
               $display("FAIL reset_in_pulse: got start=%b busy=%b cnt=%0d, want 0/0/0", start, busy, step_cnt);
            end
            reset = 1'b0;
         end
      end
      n_tests++;
      if (!hit) begin
         n_fail++;
         $display("FAIL reset_in_pulse: got no start within 20 cycles, want a pulse");
      end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_auto();
      test_manual_pending();
      test_timeout();
      test_onehot();
      test_wrap_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
